// File: rtl/sa_pkg.sv
// sa_pkg: shared definitions for the output-stationary systolic array.
//   sa_state_t    - job sequencer states
//   SA_* consts   - default geometry and operand width
//   clog2_min1    - index width that never collapses to zero bits
//   max2          - integer maximum used for counter sizing
package sa_pkg;

   localparam int SA_N     = 8;
   localparam int SA_ROWS  = 4;
   localparam int SA_COLS  = 4;
   localparam int SA_K_MAX = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } sa_state_t;

   function automatic int clog2_min1(input int v);
      int w;
      w = $clog2(v);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sa_pe.sv
// sa_pe: one multiply-accumulate cell of the array.
//   clk, reset     - clock, async active-high reset
//   clear          - synchronous clear of accumulator and overflow (job start)
//   signed_mode    - 1 = operands are two's complement
//   a_valid, a     - tagged A operand arriving from the row skew line
//   b_valid, b     - tagged B operand arriving from the column skew line
//   acc            - saturating accumulator
//   overflow       - sticky: some accumulation saturated since last clear
module sa_pe
   import sa_pkg::*;
#(
   parameter int N     = SA_N,
   parameter int ACC_W = 2*SA_N+4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             signed_mode,
   input  logic             a_valid,
   input  logic [N-1:0]     a,
   input  logic             b_valid,
   input  logic [N-1:0]     b,
   output logic [ACC_W-1:0] acc,
   output logic             overflow
);

   logic [2*N-1:0]   prod_u, prod_s, prod;
   logic [ACC_W:0]   ext, acc_x, sum;
   logic [ACC_W-1:0] nxt;
   logic             ovf_now;

   // Low 2N bits of the product of sign-extended operands equal the signed product.
   assign prod_u = {{N{1'b0}}, a} * {{N{1'b0}}, b};
   assign prod_s = {{N{a[N-1]}}, a} * {{N{b[N-1]}}, b};

   // One guard bit above ACC_W exposes both signed and unsigned overflow.
   always_comb begin
      prod    = signed_mode ? prod_s : prod_u;
      ext     = {{(ACC_W+1-2*N){signed_mode & prod[2*N-1]}}, prod};
      acc_x   = {signed_mode & acc[ACC_W-1], acc};
      sum     = acc_x + ext;
      nxt     = sum[ACC_W-1:0];
      ovf_now = 1'b0;
      if (signed_mode) begin
         if (sum[ACC_W] != sum[ACC_W-1]) begin
            ovf_now = 1'b1;
            nxt     = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         end
      end else if (sum[ACC_W]) begin
         ovf_now = 1'b1;
         nxt     = '1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc      <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         acc      <= '0;
         overflow <= 1'b0;
      end else if (a_valid && b_valid) begin
         acc <= nxt;
         if (ovf_now) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/sa_os_array.sv
// sa_os_array: ROWS x COLS output-stationary systolic matrix multiplier.
//   clk, reset               - clock, async active-high reset
//   start, k_len, signed_mode- job request, sampled only in IDLE
//   in_valid / in_ready      - operand beat handshake (a_vec column, b_vec row)
//   out_valid / out_ready    - result row handshake
//   out_row, out_row_idx     - accumulators of the presented row and its index
//   busy, done, overflow     - not-IDLE, end-of-job pulse, sticky saturation
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_FEED  | accepting k_len operand beats
// ST_FLUSH | ROWS+COLS-1 cycles for the last beat to reach PE(ROWS-1,COLS-1)
// ST_DRAIN | presenting rows 0..ROWS-1 on the output handshake
module sa_os_array
   import sa_pkg::*;
#(
   parameter int N     = SA_N,
   parameter int ROWS  = SA_ROWS,
   parameter int COLS  = SA_COLS,
   parameter int ACC_W = 2*N+4,
   parameter int K_MAX = SA_K_MAX
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [$clog2(K_MAX+1)-1:0]    k_len,
   input  logic                          signed_mode,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [ROWS*N-1:0]             a_vec,
   input  logic [COLS*N-1:0]             b_vec,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [COLS*ACC_W-1:0]         out_row,
   output logic [clog2_min1(ROWS)-1:0]   out_row_idx,
   output logic                          busy,
   output logic                          done,
   output logic                          overflow
);

   localparam int IW = clog2_min1(ROWS);
   localparam int CW = clog2_min1(max2(K_MAX, ROWS+COLS-1) + 1);
   localparam logic [CW-1:0] FLUSH_LEN = CW'(ROWS+COLS-1);

   sa_state_t        state_q, state_n;
   logic [CW-1:0]    cnt_q, cnt_n;
   logic [IW-1:0]    idx_q, idx_n;
   logic             done_q, done_n;
   logic             sgn_q;
   logic             clear;
   logic             beat;

   logic [N:0]       a_tap  [ROWS][COLS];
   logic [N:0]       b_tap  [ROWS][COLS];
   logic [ACC_W-1:0] acc    [ROWS][COLS];
   logic             pe_ovf [ROWS][COLS];

   assign beat = (state_q == ST_FEED) && in_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         sgn_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         idx_q   <= idx_n;
         done_q  <= done_n;
         if (clear) sgn_q <= signed_mode;
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      idx_n   = idx_q;
      done_n  = 1'b0;
      clear   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               clear = 1'b1;
               idx_n = '0;
               if (k_len != '0) begin
                  state_n = ST_FEED;
                  cnt_n   = CW'(k_len);
               end else begin
                  state_n = ST_DRAIN;
               end
            end
         end
         ST_FEED: begin
            if (beat) begin
               if (cnt_q == CW'(1)) begin
                  state_n = ST_FLUSH;
                  cnt_n   = FLUSH_LEN;
               end else begin
                  cnt_n = cnt_q - CW'(1);
               end
            end
         end
         ST_FLUSH: begin
            if (cnt_q == CW'(1)) begin
               state_n = ST_DRAIN;
               cnt_n   = '0;
               idx_n   = '0;
            end else begin
               cnt_n = cnt_q - CW'(1);
            end
         end
         ST_DRAIN: begin
            if (out_ready) begin
               if (idx_q == IW'(ROWS-1)) begin
                  state_n = ST_IDLE;
                  idx_n   = '0;
                  done_n  = 1'b1;
               end else begin
                  idx_n = idx_q + IW'(1);
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign in_ready    = (state_q == ST_FEED);
   assign out_valid   = (state_q == ST_DRAIN);
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign out_row_idx = idx_q;

   // Row r delay line: tap r+c feeds PE(r,c), so the first r stages are the
   // input skew and the remaining stages model the left-to-right PE hop.
   for (genvar r = 0; r < ROWS; r++) begin : g_arow
      logic [N:0] sh [0:r+COLS-1];
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < r+COLS; i++) sh[i] <= '0;
         end else begin
            sh[0] <= beat ? {1'b1, a_vec[r*N +: N]} : '0;
            for (int i = 1; i < r+COLS; i++) sh[i] <= sh[i-1];
         end
      end
      for (genvar c = 0; c < COLS; c++) begin : g_tap
         assign a_tap[r][c] = sh[r+c];
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_bcol
      logic [N:0] sh [0:c+ROWS-1];
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < c+ROWS; i++) sh[i] <= '0;
         end else begin
            sh[0] <= beat ? {1'b1, b_vec[c*N +: N]} : '0;
            for (int i = 1; i < c+ROWS; i++) sh[i] <= sh[i-1];
         end
      end
      for (genvar r = 0; r < ROWS; r++) begin : g_tap
         assign b_tap[r][c] = sh[c+r];
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         sa_pe #(.N(N), .ACC_W(ACC_W)) u_pe (
            .clk         (clk),
            .reset       (reset),
            .clear       (clear),
            .signed_mode (sgn_q),
            .a_valid     (a_tap[r][c][N]),
            .a           (a_tap[r][c][N-1:0]),
            .b_valid     (b_tap[r][c][N]),
            .b           (b_tap[r][c][N-1:0]),
            .acc         (acc[r][c]),
            .overflow    (pe_ovf[r][c])
         );
      end
   end

   always_comb begin
      out_row = '0;
      if (state_q == ST_DRAIN) begin
         for (int c = 0; c < COLS; c++) out_row[c*ACC_W +: ACC_W] = acc[idx_q][c];
      end
   end

   always_comb begin
      overflow = 1'b0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            overflow = overflow | pe_ovf[r][c];
   end

endmodule

// File: doc/sa_os_array.md
SA_OS_ARRAY -- requirements
Module: sa_os_array

Interface
REQ-001 Parameter N, 8, operand width in bits.
REQ-002 Parameter ROWS, 4, PE rows (A operands per beat).
REQ-003 Parameter COLS, 4, PE columns (B operands per beat).
REQ-004 Parameter ACC_W, 2*N+4, accumulator width; SHALL be >= 2*N.
REQ-005 Parameter K_MAX, 16, maximum reduction length.
REQ-006 Port clk  in  1  single clock; all state on rising edge.
REQ-007 Port reset  in  1  asynchronous, active-high reset.
REQ-008 Port start  in  1  begin a job; sampled only in IDLE.
REQ-009 Port k_len  in  clog2(K_MAX+1)  beats in the job; sampled with start.
REQ-010 Port signed_mode  in  1  1 = two's-complement operands; sampled with start.
REQ-011 Port in_valid / in_ready  in / out  1 / 1  operand beat handshake.
REQ-012 Port a_vec  in  ROWS*N  one A column; row r at bits [r*N +: N].
REQ-013 Port b_vec  in  COLS*N  one B row; column c at bits [c*N +: N].
REQ-014 Port out_valid / out_ready  out / in  1 / 1  result row handshake.
REQ-015 Port out_row  out  COLS*ACC_W  accumulators of row out_row_idx.
REQ-016 Port out_row_idx  out  clog2(ROWS)  row being presented.
REQ-017 Port busy, done, overflow  out  1 each  not-IDLE; one-cycle pulse on final row accepted; sticky saturation flag for current job.

Function
REQ-018 Output-stationary: PE(r,c) SHALL compute sum over k of a[r][k]*b[k][c].
REQ-019 FSM states IDLE, FEED, FLUSH, DRAIN; IDLE->FEED on start with k_len>0; IDLE->DRAIN on start with k_len=0; FEED->FLUSH after k_len beats accepted; FLUSH->DRAIN after ROWS+COLS-1 cycles; DRAIN->IDLE when row ROWS-1 is accepted.
REQ-020 On start, all accumulators and overflow SHALL clear in the same edge.
REQ-021 in_ready SHALL be 1 only in FEED; a beat transfers when in_valid && in_ready.
REQ-022 Row r of a_vec SHALL be skewed by r cycles, column c of b_vec by c cycles; each operand carries a valid tag so idle FEED cycles are bubbles that never accumulate.
REQ-023 Products 2*N bits, sign- or zero-extended per signed_mode to ACC_W; accumulation SHALL saturate to the ACC_W signed/unsigned bound and set overflow.
REQ-024 out_valid SHALL be 1 throughout DRAIN; out_row_idx starts at 0, increments on each out_valid && out_ready.
REQ-025 out_row and out_row_idx SHALL hold stable while out_valid && !out_ready.
REQ-026 start while busy SHALL be ignored; k_len, signed_mode changes during a job SHALL have no effect.
REQ-027 done SHALL pulse exactly one cycle, coincident with the return to IDLE.

Reset
REQ-028 reset SHALL force IDLE immediately, mid-job included; all accumulators, skew registers, counters to 0.
REQ-029 Reset values: in_ready=0, out_valid=0, out_row=0, out_row_idx=0, busy=0, done=0, overflow=0.

Structure
REQ-030 Package sa_pkg SHALL hold the FSM state enum, default parameter constants and width helper functions.
REQ-031 One sub-module sa_pe SHALL implement a single MAC with valid tag, signed/unsigned extension, saturation and overflow output; sa_os_array instantiates ROWS*COLS of them via generate.

Verification (defaults N=8, ROWS=COLS=4 unless stated)
REQ-032 All a=1, b=2, k_len=4, unsigned, in_valid held high -> every accumulator 8; out_valid first rises 4+7 cycles after first accepted beat; done after 4 row transfers.
REQ-033 a=0xFD, b=5, k_len=2: signed_mode=1 -> all outputs -30; signed_mode=0 -> 2530; overflow=0 both.
REQ-034 ACC_W=16, unsigned, a=b=255, k_len=2 -> outputs 65535, overflow=1.
REQ-035 Repeat REQ-032 with in_valid toggling every cycle and out_ready low 3 cycles on row 1 -> identical results, out_row stable while stalled.
REQ-036 reset pulsed mid-FEED, then REQ-032 rerun -> all outputs 0 during/after reset, rerun yields 8 everywhere.
REQ-037 start with k_len=0 -> no in_ready, four zero rows, done pulse.
